// File: rtl/mult_link_pkg.sv
// mult_link_pkg: shared types and widths for the link-side multiplier
// controller (mult_link_ctrl) and its shift-add core (seq_mult8).
//
// Contents:
//   state_t      controller FSM states; SEND_CK/WAIT_CK exist only when
//                MULT_LINK_CHECKSUM_EN is defined
//   src_t        requester identity (UART or SPI)
//   BYTE_W       operand / link byte width
//   PROD_W       full product width
//   other_src()  returns the opposite requester
package mult_link_pkg;

  localparam int BYTE_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    GET_B,
    MUL,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
`ifdef MULT_LINK_CHECKSUM_EN
    ,
    SEND_CK,
    WAIT_CK
`endif
  } state_t;

  typedef enum logic {
    SRC_UART = 1'b0,
    SRC_SPI  = 1'b1
  } src_t;

  function automatic src_t other_src(input src_t s);
    return (s == SRC_UART) ? SRC_SPI : SRC_UART;
  endfunction

endpackage

// File: rtl/mult_link_ctrl_seq_mult8.sv
// seq_mult8: unsigned 8x8 shift-add multiplier, one multiplier bit per cycle.
//
// Bit 0 of the multiplier is folded into the load cycle, so the product is
// final and done pulses 7 clocks after the start edge. The owning FSM then
// sees done one cycle later, giving it exactly 8 cycles in its MUL state.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-low reset
//   start    load a/b and begin (single-cycle strobe)
//   a, b     unsigned operands (multiplicand, multiplier)
//   done     one-cycle pulse, product is final
//   product  16-bit result, held until the next start
module seq_mult8
  import mult_link_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [BYTE_W-1:0] mplier;
  logic [2:0]        bit_cnt;
  logic              running;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous -- only evaluated inside the clocked block.
    if (!reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      bit_cnt <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= b[0] ? {{(PROD_W-BYTE_W){1'b0}}, a} : '0;
        mcand   <= {{(PROD_W-BYTE_W-1){1'b0}}, a, 1'b0};
        mplier  <= {1'b0, b[BYTE_W-1:1]};
        bit_cnt <= 3'd1;
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/mult_link_ctrl.sv
// mult_link_ctrl: transaction controller between the UART/SPI front-end and
// a shared 8x8 multiplier. Takes operand A then operand B from one requester,
// multiplies, and returns the 16-bit product high byte first on the
// requester's transmit path.
//
// Optional feature: define MULT_LINK_CHECKSUM_EN to append a third byte,
// product[15:8] ^ product[7:0], with the same handshake.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles waiting for operand B before abandoning
//   FIRST_PRIO_SPI  reset value of owner and of the round-robin priority
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   uart_rx_valid/uart_rx_data    received UART byte strobe/data
//   uart_tx_ready                 UART transmitter idle
//   uart_tx_start/uart_tx_data    UART transmit launch strobe/data
//   spi_rx_valid/spi_rx_data      received SPI byte strobe/data
//   spi_tx_done                   SPI byte shifted out strobe
//   spi_start/spi_tx_data         SPI transmit load strobe/data
//   busy                          transaction in progress
//   owner                         current/last owner (0 UART, 1 SPI)
//   drop_err                      sticky: some byte was rejected
module mult_link_ctrl
  import mult_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIRST_PRIO_SPI = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_tx_ready,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  input  logic       spi_rx_valid,
  input  logic [7:0] spi_rx_data,
  input  logic       spi_tx_done,
  output logic       spi_start,
  output logic [7:0] spi_tx_data,
  output logic       busy,
  output logic       owner,
  output logic       drop_err
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam src_t RESET_SRC = (FIRST_PRIO_SPI != 0) ? SRC_SPI : SRC_UART;

  state_t            state;
  src_t              owner_q;
  src_t              prio;
  logic [BYTE_W-1:0] op_a;
  logic [TO_W-1:0]   to_cnt;
  logic              uart_seen_low;

  logic              owner_valid;
  logic              other_valid;
  logic [BYTE_W-1:0] owner_data;
  logic              is_send;
  logic              is_wait;
  logic              wait_exit;
  logic [BYTE_W-1:0] send_byte;
  state_t            wait_state;
  state_t            after_wait;

  logic              mul_start;
  logic              mul_done;
  logic [PROD_W-1:0] product;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    owner_valid = (owner_q == SRC_UART) ? uart_rx_valid : spi_rx_valid;
    other_valid = (owner_q == SRC_UART) ? spi_rx_valid  : uart_rx_valid;
    owner_data  = (owner_q == SRC_UART) ? uart_rx_data  : spi_rx_data;
    is_send     = 1'b0;
    is_wait     = 1'b0;
    send_byte   = '0;
    wait_state  = WAIT_HI;
    after_wait  = IDLE;
    case (state)
      SEND_HI: begin
        is_send    = 1'b1;
        send_byte  = product[PROD_W-1:BYTE_W];
        wait_state = WAIT_HI;
      end
      SEND_LO: begin
        is_send    = 1'b1;
        send_byte  = product[BYTE_W-1:0];
        wait_state = WAIT_LO;
      end
      WAIT_HI: begin
        is_wait    = 1'b1;
        after_wait = SEND_LO;
      end
      WAIT_LO: begin
        is_wait    = 1'b1;
`ifdef MULT_LINK_CHECKSUM_EN
        after_wait = SEND_CK;
`else
        after_wait = IDLE;
`endif
      end
`ifdef MULT_LINK_CHECKSUM_EN
      SEND_CK: begin
        is_send    = 1'b1;
        send_byte  = product[PROD_W-1:BYTE_W] ^ product[BYTE_W-1:0];
        wait_state = WAIT_CK;
      end
      WAIT_CK: begin
        is_wait    = 1'b1;
        after_wait = IDLE;
      end
`endif
      default: ;
    endcase
    // UART wait needs a full busy cycle (ready low, then high again).
    wait_exit = (owner_q == SRC_UART) ? (uart_seen_low && uart_tx_ready)
                                      : spi_tx_done;
    // Operand B goes straight into the multiplier on the accepting edge.
    mul_start = (state == GET_B) && owner_valid;
  end

  seq_mult8 u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (owner_data),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      owner_q       <= RESET_SRC;
      prio          <= RESET_SRC;
      op_a          <= '0;
      to_cnt        <= '0;
      uart_seen_low <= 1'b0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
      spi_start     <= 1'b0;
      spi_tx_data   <= '0;
      drop_err      <= 1'b0;
    end else begin
      uart_tx_start <= 1'b0;
      spi_start     <= 1'b0;

      // Once the multiply starts, nothing is accepted until IDLE.
      if (state != IDLE && state != GET_B && (uart_rx_valid || spi_rx_valid))
        drop_err <= 1'b1;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (uart_rx_valid && spi_rx_valid) begin
            owner_q  <= prio;
            op_a     <= (prio == SRC_UART) ? uart_rx_data : spi_rx_data;
            prio     <= other_src(prio);
            drop_err <= 1'b1;
            state    <= GET_B;
          end else if (uart_rx_valid) begin
            owner_q <= SRC_UART;
            op_a    <= uart_rx_data;
            state   <= GET_B;
          end else if (spi_rx_valid) begin
            owner_q <= SRC_SPI;
            op_a    <= spi_rx_data;
            state   <= GET_B;
          end
        end

        GET_B: begin
          if (other_valid) drop_err <= 1'b1;
          if (owner_valid) begin
            state <= MUL;
          end else if (to_cnt == TO_LAST) begin
            drop_err <= 1'b1;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        MUL: begin
          if (mul_done) state <= SEND_HI;
        end

        default: begin
          if (is_send) begin
            if (owner_q == SRC_SPI) begin
              spi_start   <= 1'b1;
              spi_tx_data <= send_byte;
              state       <= wait_state;
            end else if (uart_tx_ready) begin
              uart_tx_start <= 1'b1;
              uart_tx_data  <= send_byte;
              uart_seen_low <= 1'b0;
              state         <= wait_state;
            end
          end else if (is_wait) begin
            if (!uart_tx_ready) uart_seen_low <= 1'b1;
            if (wait_exit) begin
              state <= after_wait;
              if (after_wait == IDLE) prio <= other_src(owner_q);
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_mult_link_ctrl.sv
// tb_mult_link_ctrl: directed self-checking bench for mult_link_ctrl.
// Small behavioural UART/SPI transmitter models answer the controller's
// strobes; a monitor logs every transmitted byte for comparison.
module tb_mult_link_ctrl;

`ifdef MULT_LINK_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic       clk;
  logic       reset;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_tx_ready;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_rx_data;
  logic       spi_tx_done;
  logic       spi_start;
  logic [7:0] spi_tx_data;
  logic       busy;
  logic       owner;
  logic       drop_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] u_bytes[8];
  logic [7:0] s_bytes[8];
  int         u_n = 0;
  int         s_n = 0;
  logic       uart_auto = 1'b1;

  mult_link_ctrl #(
    .TIMEOUT_CYCLES (16),
    .FIRST_PRIO_SPI (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .spi_rx_valid  (spi_rx_valid),
    .spi_rx_data   (spi_rx_data),
    .spi_tx_done   (spi_tx_done),
    .spi_start     (spi_start),
    .spi_tx_data   (spi_tx_data),
    .busy          (busy),
    .owner         (owner),
    .drop_err      (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: log every transmit strobe with its data.
  initial begin
    forever begin
      tick();
      if (uart_tx_start) begin
        if (u_n < 8) u_bytes[u_n] = uart_tx_data;
        u_n++;
      end
      if (spi_start) begin
        if (s_n < 8) s_bytes[s_n] = spi_tx_data;
        s_n++;
      end
    end
  end

  // UART transmitter: busy for 3 cycles per byte; stalls if uart_auto==0.
  initial begin
    forever begin
      tick();
      if (uart_tx_start) begin
        uart_tx_ready = 1'b0;
        repeat (3) tick();
        if (uart_auto) uart_tx_ready = 1'b1;
      end
    end
  end

  // SPI slave: reports the byte shifted out 4 cycles after the load.
  initial begin
    forever begin
      tick();
      if (spi_start) begin
        repeat (4) tick();
        spi_tx_done = 1'b1;
        tick();
        spi_tx_done = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    u_n = 0;
    s_n = 0;
  endtask

  task automatic send_uart(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_spi(input logic [7:0] b);
    spi_rx_data  = b;
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
  endtask

  task automatic send_both(input logic [7:0] ub, input logic [7:0] sb);
    uart_rx_data  = ub;
    spi_rx_data   = sb;
    uart_rx_valid = 1'b1;
    spi_rx_valid  = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
    spi_rx_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    n_assert++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_assert++;
    if ({busy, owner, drop_err, uart_tx_start, spi_start} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, owner, drop_err, uart_tx_start, spi_start});
    end
    n_assert++;
    if ({uart_tx_data, spi_tx_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0000", {uart_tx_data, spi_tx_data});
    end
    reset = 1'b1;
  endtask

  task automatic test_uart_mult();
    logic [7:0] exp[3];
    int c;
    exp[0] = 8'h00; exp[1] = 8'h84; exp[2] = 8'h84;
    do_reset();
    send_uart(8'h0C);
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL uart_busy_after_a: got %b expected 1", busy);
    end
    send_uart(8'h0B);
    c = 0;
    while (!uart_tx_start && c < 40) begin
      tick();
      c++;
    end
    n_assert++;
    if (c != 9) begin
      n_fail++;
      $display("FAIL uart_latency: got %0d expected 9", c);
    end
    wait_idle("uart_idle", 200);
    n_assert++;
    if (u_n != NB || s_n != 0) begin
      n_fail++;
      $display("FAIL uart_counts: got u=%0d s=%0d expected u=%0d s=0", u_n, s_n, NB);
    end
    for (int i = 0; i < NB && i < u_n; i++) begin
      n_assert++;
      if (u_bytes[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL uart_byte%0d: got %h expected %h", i, u_bytes[i], exp[i]);
      end
    end
    n_assert++;
    if ({owner, drop_err, spi_tx_data} !== 10'h000) begin
      n_fail++;
      $display("FAIL uart_end_state: got owner=%b drop=%b spi_data=%h expected 0 0 00",
               owner, drop_err, spi_tx_data);
    end
  endtask

  task automatic test_spi_mult();
    logic [7:0] exp[3];
    exp[0] = 8'hFE; exp[1] = 8'h01; exp[2] = 8'hFF;
    do_reset();
    send_spi(8'hFF);
    send_spi(8'hFF);
    wait_idle("spi_idle", 200);
    n_assert++;
    if (s_n != NB || u_n != 0) begin
      n_fail++;
      $display("FAIL spi_counts: got s=%0d u=%0d expected s=%0d u=0", s_n, u_n, NB);
    end
    for (int i = 0; i < NB && i < s_n; i++) begin
      n_assert++;
      if (s_bytes[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL spi_byte%0d: got %h expected %h", i, s_bytes[i], exp[i]);
      end
    end
    n_assert++;
    if ({owner, drop_err, uart_tx_data} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL spi_end_state: got owner=%b drop=%b uart_data=%h expected 1 0 00",
               owner, drop_err, uart_tx_data);
    end
  endtask

  task automatic test_collision();
    logic [7:0] exp_u[3];
    logic [7:0] exp_s[3];
    exp_u[0] = 8'h00; exp_u[1] = 8'h0E; exp_u[2] = 8'h0E;
    exp_s[0] = 8'h00; exp_s[1] = 8'h0F; exp_s[2] = 8'h0F;
    do_reset();
    send_both(8'h07, 8'h09);
    n_assert++;
    if ({busy, owner, drop_err} !== 3'b101) begin
      n_fail++;
      $display("FAIL coll1_win: got busy/owner/drop=%b expected 101", {busy, owner, drop_err});
    end
    send_uart(8'h02);
    wait_idle("coll1_idle", 200);
    for (int i = 0; i < NB; i++) begin
      n_assert++;
      if (u_bytes[i] !== exp_u[i] || u_n != NB) begin
        n_fail++;
        $display("FAIL coll1_byte%0d: got %h (n=%0d) expected %h", i, u_bytes[i], u_n, exp_u[i]);
      end
    end
    u_n = 0;
    s_n = 0;
    send_both(8'h01, 8'h03);
    n_assert++;
    if ({busy, owner, drop_err} !== 3'b111) begin
      n_fail++;
      $display("FAIL coll2_win: got busy/owner/drop=%b expected 111", {busy, owner, drop_err});
    end
    send_spi(8'h05);
    wait_idle("coll2_idle", 200);
    for (int i = 0; i < NB; i++) begin
      n_assert++;
      if (s_bytes[i] !== exp_s[i] || s_n != NB || u_n != 0) begin
        n_fail++;
        $display("FAIL coll2_byte%0d: got %h (s=%0d u=%0d) expected %h",
                 i, s_bytes[i], s_n, u_n, exp_s[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int c = 0;
    do_reset();
    send_uart(8'h05);
    while (busy && c < 100) begin
      tick();
      c++;
    end
    n_assert++;
    if (c != 16) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d expected 16", c);
    end
    n_assert++;
    if ({busy, drop_err} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_flags: got busy/drop=%b expected 01", {busy, drop_err});
    end
    repeat (5) tick();
    n_assert++;
    if (u_n != 0 || s_n != 0) begin
      n_fail++;
      $display("FAIL timeout_strobes: got u=%0d s=%0d expected 0 0", u_n, s_n);
    end
  endtask

  task automatic test_drop_in_mul();
    logic [7:0] exp[3];
    exp[0] = 8'h00; exp[1] = 8'h0C; exp[2] = 8'h0C;
    do_reset();
    send_uart(8'h03);
    send_uart(8'h04);
    tick();
    n_assert++;
    if (drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_drop_pre: got %b expected 0", drop_err);
    end
    send_spi(8'h55);
    n_assert++;
    if (drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_drop_set: got %b expected 1", drop_err);
    end
    wait_idle("mul_drop_idle", 200);
    for (int i = 0; i < NB; i++) begin
      n_assert++;
      if (u_bytes[i] !== exp[i] || u_n != NB || s_n != 0) begin
        n_fail++;
        $display("FAIL mul_drop_byte%0d: got %h (u=%0d s=%0d) expected %h",
                 i, u_bytes[i], u_n, s_n, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[3];
    int c = 0;
    exp[0] = 8'h00; exp[1] = 8'h06; exp[2] = 8'h06;
    do_reset();
    uart_auto = 1'b0;
    send_uart(8'h09);
    send_uart(8'h09);
    while (!uart_tx_start && c < 40) begin
      tick();
      c++;
    end
    tick();
    tick();
    n_assert++;
    if (busy !== 1'b1 || u_n != 1) begin
      n_fail++;
      $display("FAIL mid_stalled: got busy=%b u=%0d expected 1 1", busy, u_n);
    end
    reset = 1'b0;
    tick();
    n_assert++;
    if ({busy, owner, drop_err, uart_tx_start, spi_start, uart_tx_data, spi_tx_data}
        !== 21'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 000000",
               {busy, owner, drop_err, uart_tx_start, spi_start, uart_tx_data, spi_tx_data});
    end
    reset = 1'b1;
    u_n = 0;
    s_n = 0;
    repeat (4) tick();
    uart_tx_ready = 1'b1;
    uart_auto = 1'b1;
    n_assert++;
    if (u_n != 0 || s_n != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_strobes: got u=%0d s=%0d busy=%b expected 0 0 0", u_n, s_n, busy);
    end
    send_uart(8'h02);
    send_uart(8'h03);
    wait_idle("mid_idle", 200);
    for (int i = 0; i < NB; i++) begin
      n_assert++;
      if (u_bytes[i] !== exp[i] || u_n != NB) begin
        n_fail++;
        $display("FAIL mid_byte%0d: got %h (n=%0d) expected %h", i, u_bytes[i], u_n, exp[i]);
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_tx_ready = 1'b1;
    spi_rx_valid  = 1'b0;
    spi_rx_data   = 8'h00;
    spi_tx_done   = 1'b0;
    tick();
    test_reset();
    test_uart_mult();
    test_spi_mult();
    test_collision();
    test_timeout();
    test_drop_in_mul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
